// File: rtl/rv32m_divider.sv
// Multi-cycle radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// Divide-by-zero and signed overflow finish in one edge; all other ops take WIDTH+2 edges.
module rv32m_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_start,
    input  logic [2:0]       i_funct3,
    input  logic [WIDTH-1:0] i_dividend,
    input  logic [WIDTH-1:0] i_divisor,
    input  logic             i_flush,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_result
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_quot;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_dvsr;
    logic [WIDTH-1:0] r_result;
    logic [CW-1:0]    r_count;
    logic             r_isRem;
    logic             r_negQuot;
    logic             r_negRem;
    logic             r_busy;
    logic             r_done;

    logic             w_accept;
    logic             w_signed;
    logic             w_divZero;
    logic             w_overflow;
    logic [WIDTH-1:0] w_absDividend;
    logic [WIDTH-1:0] w_absDivisor;
    logic [WIDTH-1:0] w_remShift;
    logic [WIDTH:0]   w_diff;
    logic [WIDTH-1:0] w_quotFixed;
    logic [WIDTH-1:0] w_remFixed;
    logic             w_unused;

    assign w_accept      = i_start & ~r_busy & ~i_flush;
    assign w_signed      = ~i_funct3[0];
    assign w_divZero     = (i_divisor == '0);
    assign w_overflow    = w_signed && (i_dividend == {1'b1, {(WIDTH-1){1'b0}}})
                           && (i_divisor == '1);
    assign w_absDividend = (w_signed && i_dividend[WIDTH-1]) ? -i_dividend : i_dividend;
    assign w_absDivisor  = (w_signed && i_divisor[WIDTH-1])  ? -i_divisor  : i_divisor;

    // The partial remainder stays below the divisor, so the extra subtractor bit is only a borrow flag.
    assign w_remShift    = {r_rem[WIDTH-2:0], r_quot[WIDTH-1]};
    assign w_diff        = {1'b0, w_remShift} - {1'b0, r_dvsr};
    assign w_quotFixed   = r_negQuot ? -r_quot : r_quot;
    assign w_remFixed    = r_negRem  ? -r_rem  : r_rem;

    // funct3[2] is always set for divider ops and carries no information here.
    assign w_unused      = i_funct3[2];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_result  <= '0;
            r_count   <= '0;
            r_quot    <= '0;
            r_rem     <= '0;
            r_dvsr    <= '0;
            r_isRem   <= 1'b0;
            r_negQuot <= 1'b0;
            r_negRem  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    if (w_accept) begin
                        r_isRem <= i_funct3[1];
                        if (w_divZero) begin
                            r_state  <= S_DONE;
                            r_done   <= 1'b1;
                            r_result <= i_funct3[1] ? i_dividend : '1;
                        end else if (w_overflow) begin
                            r_state  <= S_DONE;
                            r_done   <= 1'b1;
                            r_result <= i_funct3[1] ? '0 : i_dividend;
                        end else begin
                            r_state   <= S_CALC;
                            r_busy    <= 1'b1;
                            r_quot    <= w_absDividend;
                            r_dvsr    <= w_absDivisor;
                            r_rem     <= '0;
                            r_count   <= '0;
                            r_negQuot <= w_signed & (i_dividend[WIDTH-1] ^ i_divisor[WIDTH-1]);
                            r_negRem  <= w_signed & i_dividend[WIDTH-1];
                        end
                    end
                end
                S_CALC: begin
                    if (i_flush) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_quot  <= {r_quot[WIDTH-2:0], ~w_diff[WIDTH]};
                        r_rem   <= w_diff[WIDTH] ? w_remShift : w_diff[WIDTH-1:0];
                        r_count <= r_count + 1'b1;
                        if (r_count == CW'(WIDTH-1)) begin
                            r_state <= S_FIX;
                        end
                    end
                end
                S_FIX: begin
                    r_busy <= 1'b0;
                    if (i_flush) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_result <= r_isRem ? w_remFixed : w_quotFixed;
                        r_state  <= S_DONE;
                        r_done   <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign o_busy   = r_busy;
    assign o_done   = r_done;
    assign o_result = r_result;

endmodule
